dpram_be_clr: RTL and testbench
===============================

# dpram_be_clr

Parametrised successor to the team's simple dual-port BRAM. It adds per-byte write enables, write-first forwarding on same-address read/write collisions, a post-reset clear sequencer, a read-valid flag, and an optional output register. It sits between the VGA/game-logic writers and the display-side readers, e.g. tile/frame buffers, and must still infer block RAM.

## Interface
Parameters:
- dwidth, 16, data width in bits; must be a multiple of 8.
- addr_width, 10, address width; depth = 1<<addr_width.
- CLEAR_VAL, 0, dwidth-bit word written to every location by the clear sequencer.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- raddr  in  addr_width  read address.
- re  in  1  read enable.
- waddr  in  addr_width  write address.
- wdata  in  dwidth  write data.
- wbe  in  dwidth/8  byte write enables; bit i controls wdata[8i+7:8i].
- we  in  1  write enable.
- clr_req  in  1  one-cycle pulse requesting a full memory clear.
- ready  out  1  high when the clear is done and user writes are accepted.
- rdata  out  dwidth  read data.
- rvalid  out  1  high for one cycle when rdata carries a fresh read result.

## Operation
- FSM states: CLEAR and READY.
- Reset asserted:
  - state = CLEAR, clear counter = 0.
  - ready = 0, rvalid = 0, rdata = 0 (the output register, if present, is also 0).
  - Memory contents are not reset by this; the sequencer clears them.
- CLEAR state:
  - Each cycle, write CLEAR_VAL to mem[counter] with all bytes enabled, then increment the counter.
  - When the counter = depth-1, write that last location and go to READY on the next edge. The counter wraps to 0.
  - User we is ignored (dropped, not queued). re is ignored and rvalid stays 0.
  - clr_req is ignored.
- READY state:
  - ready = 1.
  - Write: if we=1, every byte i with wbe[i]=1 is written to mem[waddr]; other bytes keep their value. we=1 with wbe=0 is a no-op.
  - Read: if re=1, rdata gets mem[raddr] and rvalid = 1 on the next cycle.
  - If re=0, rdata holds its previous value and rvalid = 0.
  - Collision (re and we in the same cycle, raddr == waddr): write-first. rdata returns, per byte, wdata where wbe=1 and the old memory byte where wbe=0.
  - clr_req=1: the write in that same cycle still happens, then the FSM enters CLEAR with counter 0. ready drops on the next edge.
- Reset during CLEAR restarts the clear from address 0.

## Timing
- Clear takes exactly depth cycles. ready rises on the edge after the depth-th clear write; for addr_width=4 that is 16 cycles after reset deasserts.
- Read latency is 1 cycle from the re edge to rdata/rvalid (2 cycles with the output register).
- A write becomes visible to a non-colliding read issued on the following cycle.
- The read issued in the cycle of a clr_req is still served. Reads issued during CLEAR produce no rvalid.

## Configuration
- DPRAM_OUTREG_EN defined:
  - Adds an output pipeline register on rdata and rvalid; latency is 2 cycles.
  - Forwarding is resolved in stage 1.
  - The register is reset to 0 and loads every cycle. rdata follows stage 1, so it holds its value when re=0.
- DPRAM_OUTREG_EN undefined: 1-cycle latency, with rdata driven directly from the BRAM read register.

## Test plan
Use addr_width=4, dwidth=16.
- Clear after reset: CLEAR_VAL=16'hA5A5, release reset -> ready=0 for 16 cycles, then 1; reading addresses 0..15 returns 16'hA5A5 each with rvalid=1.
- Byte enables: write 16'h1234 to addr 3 with wbe=2'b11, then 16'hABCD with wbe=2'b01 -> reading addr 3 returns 16'h12CD.
- Collision: mem[5]=16'h0000; same cycle we=1, wbe=2'b10, wdata=16'hFF11, re=1, raddr=5 -> rdata=16'hFF00 one cycle later; a later read of addr 5 also returns 16'hFF00.
- Clear during operation: write 16'h7777 to addr 9, pulse clr_req -> ready low for 16 cycles; a we issued in that window is dropped; after ready returns, addr 9 reads CLEAR_VAL.
- Reset mid-clear: assert reset at clear count 7 -> rdata=0, rvalid=0, ready=0 immediately; after release a full 16-cycle clear runs again.
- Latency: with DPRAM_OUTREG_EN defined, rvalid follows re by exactly 2 cycles; without it, by exactly 1 cycle.

Source files
------------

// File: rtl/dpram_be_clr.sv
// dpram_be_clr: byte-enable dual-port RAM, write-first forwarding, clear sequencer; DPRAM_OUTREG_EN adds an rdata/rvalid output register
module dpram_be_clr #(
  parameter int dwidth = 16,
  parameter int addr_width = 10,
  parameter logic [dwidth-1:0] CLEAR_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [addr_width-1:0] raddr,
  input  logic                  re,
  input  logic [addr_width-1:0] waddr,
  input  logic [dwidth-1:0]     wdata,
  input  logic [dwidth/8-1:0]   wbe,
  input  logic                  we,
  input  logic                  clr_req,
  output logic                  ready,
  output logic [dwidth-1:0]     rdata,
  output logic                  rvalid
);
  localparam int nb = dwidth / 8;
  typedef enum logic {CLEAR, READY} state_t;
  state_t state_q, state_d;
  logic [addr_width-1:0] cnt_q, cnt_d;
  logic [dwidth-1:0] mem [1<<addr_width];
  logic wr_en;
  logic [addr_width-1:0] wr_addr;
  logic [dwidth-1:0] wr_data;
  logic [nb-1:0] wr_be;
  logic [dwidth-1:0] fwd, rdata_q, rdata_d;
  logic rvalid_q, rvalid_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    state_d = (state_q == CLEAR) ? ((&cnt_q) ? READY : CLEAR) : (clr_req ? CLEAR : READY);
    cnt_d = (state_q == CLEAR) ? cnt_q + 1'b1 : '0;
  end
  always_comb begin
    ready = state_q == READY;
    wr_en = ready ? we : 1'b1;
    wr_addr = ready ? waddr : cnt_q;
    wr_data = ready ? wdata : CLEAR_VAL;
    wr_be = ready ? wbe : '1;
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < nb; i++)
      if (wr_en && wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
  end
  // Write-first: enabled bytes of a same-address write replace the stale array byte
  always_comb begin
    fwd = mem[raddr];
    for (int i = 0; i < nb; i++)
      if (we && wbe[i] && raddr == waddr) fwd[8*i +: 8] = wdata[8*i +: 8];
    rvalid_d = ready && re;
    rdata_d = rvalid_d ? fwd : rdata_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end
`ifdef DPRAM_OUTREG_EN
  logic [dwidth-1:0] rdata2_q;
  logic rvalid2_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata2_q <= '0;
      rvalid2_q <= 1'b0;
    end else begin
      rdata2_q <= rdata_q;
      rvalid2_q <= rvalid_q;
    end
  end
  assign rdata = rdata2_q;
  assign rvalid = rvalid2_q;
`else
  assign rdata = rdata_q;
  assign rvalid = rvalid_q;
`endif
endmodule

// File: tb/tb_dpram_be_clr.sv
// tb_dpram_be_clr: vector table, corner sequences and random traffic against a behavioural RAM model
module tb_dpram_be_clr;
`ifdef DPRAM_OUTREG_EN
  localparam int lat = 2;
`else
  localparam int lat = 1;
`endif
  localparam logic [15:0] cv = 16'hA5A5;
  logic clk, reset, re, we, clr_req, ready, rvalid;
  logic [3:0] raddr, waddr;
  logic [15:0] wdata, rdata;
  logic [1:0] wbe;
  int checks = 0, errors = 0;
  dpram_be_clr #(.dwidth(16), .addr_width(4), .CLEAR_VAL(cv)) dut (
    .clk(clk), .reset(reset), .raddr(raddr), .re(re), .waddr(waddr), .wdata(wdata),
    .wbe(wbe), .we(we), .clr_req(clr_req), .ready(ready), .rdata(rdata), .rvalid(rvalid)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  logic [15:0] m_mem [16];
  int m_idx;
  bit m_ready, s1_v, s2_v;
  logic [15:0] s1_d, s2_d;
  task automatic model_reset();
    m_ready = 0; m_idx = 0; s1_v = 0; s2_v = 0; s1_d = 0; s2_d = 0;
  endtask
  // Write is applied before the read, which is exactly write-first behaviour
  task automatic model_step();
    logic [15:0] rd;
    bit rv;
    rv = 0; rd = s1_d;
    if (!m_ready) begin
      m_mem[m_idx] = cv;
      m_idx++;
      if (m_idx == 16) begin m_ready = 1; m_idx = 0; end
    end else begin
      if (we) for (int b = 0; b < 2; b++) if (wbe[b]) m_mem[waddr][8*b +: 8] = wdata[8*b +: 8];
      if (re) begin rv = 1; rd = m_mem[raddr]; end
      if (clr_req) begin m_ready = 0; m_idx = 0; end
    end
    s2_d = s1_d; s2_v = s1_v; s1_d = rd; s1_v = rv;
  endtask
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic set_in(logic w, logic [1:0] be, logic [3:0] wa, logic [15:0] wd, logic r, logic [3:0] ra, logic c);
    we = w; wbe = be; waddr = wa; wdata = wd; re = r; raddr = ra; clr_req = c;
  endtask
  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic cyc();
    @(posedge clk);
    if (!reset) model_step();
    #1;
    chk("cycle {ready,rvalid,rdata}", {14'd0, ready, rvalid, rdata},
        {14'd0, m_ready, (lat == 2) ? s2_v : s1_v, (lat == 2) ? s2_d : s1_d});
  endtask
  task automatic wait_ready(string nm);
    int n;
    n = 0;
    while (!ready && n < 40) begin cyc(); n++; end
    chk(nm, 32'(n), 32'd16);
  endtask
  task automatic reset_and_clear(string nm);
    reset = 1;
    #1;
    model_reset();
    chk({nm, "_zero"}, {14'd0, ready, rvalid, rdata}, 32'd0);
    @(posedge clk);
    #1;
    reset = 0;
    wait_ready(nm);
  endtask
  task automatic read_chk(logic [3:0] a, logic [15:0] exp, string nm);
    set_in(0, 0, 0, 0, 1, a, 0);
    cyc();
    idle();
    repeat (lat - 1) cyc();
    chk(nm, {15'd0, rvalid, rdata}, {15'd0, 1'b1, exp});
  endtask
  typedef struct {
    logic w; logic [1:0] be; logic [3:0] wa; logic [15:0] wd;
    logic r; logic [3:0] ra; logic ev; logic [15:0] ed;
  } vec_t;
  vec_t vt [12];
  initial begin
    vt[0]  = '{1, 2'b11, 4'd3, 16'h1234, 0, 4'd0, 0, 16'h0000};
    vt[1]  = '{1, 2'b01, 4'd3, 16'hABCD, 0, 4'd0, 0, 16'h0000};
    vt[2]  = '{0, 2'b00, 4'd0, 16'h0000, 1, 4'd3, 1, 16'h12CD};
    vt[3]  = '{1, 2'b11, 4'd5, 16'h0000, 0, 4'd0, 0, 16'h0000};
    vt[4]  = '{1, 2'b10, 4'd5, 16'hFF11, 1, 4'd5, 1, 16'hFF00};
    vt[5]  = '{0, 2'b00, 4'd0, 16'h0000, 1, 4'd5, 1, 16'hFF00};
    vt[6]  = '{0, 2'b00, 4'd0, 16'h0000, 1, 4'd0, 1, 16'hA5A5};
    vt[7]  = '{1, 2'b00, 4'd15, 16'h1111, 1, 4'd15, 1, 16'hA5A5};
    vt[8]  = '{0, 2'b00, 4'd0, 16'h0000, 1, 4'd15, 1, 16'hA5A5};
    vt[9]  = '{1, 2'b11, 4'd7, 16'hBEEF, 1, 4'd7, 1, 16'hBEEF};
    vt[10] = '{1, 2'b11, 4'd8, 16'h0102, 1, 4'd7, 1, 16'hBEEF};
    vt[11] = '{0, 2'b00, 4'd0, 16'h0000, 1, 4'd8, 1, 16'h0102};
    for (int i = 0; i < 16; i++) m_mem[i] = 16'h0;
    idle();
    reset_and_clear("clear_after_reset");
    for (int a = 0; a < 16; a++) read_chk(4'(a), cv, "clear_read");
    for (int i = 0; i < 12; i++) begin
      set_in(vt[i].w, vt[i].be, vt[i].wa, vt[i].wd, vt[i].r, vt[i].ra, 0);
      cyc();
      idle();
      repeat (lat - 1) cyc();
      chk($sformatf("vec%0d rvalid", i), {31'd0, rvalid}, {31'd0, vt[i].ev});
      if (vt[i].ev) chk($sformatf("vec%0d rdata", i), {16'd0, rdata}, {16'd0, vt[i].ed});
    end
    begin
      int n;
      idle();
      repeat (3) cyc();
      set_in(0, 0, 0, 0, 1, 4'd3, 0);
      cyc();
      idle();
      n = 1;
      while (!rvalid && n < 8) begin cyc(); n++; end
      chk("latency", 32'(n), 32'(lat));
      cyc();
      chk("rvalid_pulse", {31'd0, rvalid}, 32'd0);
    end
    set_in(1, 2'b11, 4'd9, 16'h7777, 0, 0, 0);
    cyc();
    set_in(0, 0, 0, 0, 1, 4'd9, 1);
    cyc();
    idle();
    begin
      int n;
      n = 0;
      while (!ready && n < 40) begin
        if (n == 4) set_in(1, 2'b11, 4'd2, 16'h1234, 1, 4'd2, 0); else idle();
        cyc();
        n++;
      end
      chk("clear_op_len", 32'(n), 32'd16);
    end
    idle();
    repeat (lat) cyc();
    chk("clr_cycle_read", {16'd0, rdata}, {16'd0, 16'h7777});
    read_chk(4'd9, cv, "cleared_addr9");
    read_chk(4'd2, cv, "dropped_write");
    set_in(1, 2'b11, 4'd4, 16'h4242, 1, 4'd4, 0);
    cyc();
    set_in(0, 0, 0, 0, 0, 0, 1);
    cyc();
    idle();
    repeat (7) cyc();
    chk("pre_reset_rdata", {16'd0, rdata}, {16'd0, 16'h4242});
    #2;
    reset_and_clear("mid_clear_reset");
    read_chk(4'd4, cv, "post_reset_read");
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom), 2'($urandom), 4'($urandom), 16'($urandom), 1'($urandom),
             4'($urandom_range(0, 3) == 0 ? waddr : 4'($urandom)), $urandom_range(0, 63) == 0);
      if (re && $urandom_range(0, 3) == 0) raddr = waddr;
      cyc();
    end
    idle();
    repeat (20) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
